div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_if.sv | 19 +
 rtl/div_step.sv | 16 +
 rtl/div_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions: ALU control encodings plus the divider's state
// encoding, default width and result-field indices.
package div_unit_pkg;

  localparam int DIV_WIDTH     = 32;
  localparam int DIV_QUO_FIELD = 0;  // LO half of the result
  localparam int DIV_REM_FIELD = 1;  // HI half of the result

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divStateT;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_MULT = 4'd5,
    ALU_MULTU= 4'd6,
    ALU_DIV  = 4'd7,
    ALU_DIVU = 4'd8
  } aluCtrlT;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider bus: operation request, stall request, result pulse.
interface div_unit_if import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH);

  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (output start, signed_div, annul, a, b,
                  input  stall, ready, result);

  modport slave  (input  start, signed_div, annul, a, b,
                  output stall, ready, result);

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder; the borrow decides the quotient bit.
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   partRem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             qBit
);

  logic [WIDTH:0] diff;

  assign diff    = partRem - {1'b0, divisor};
  assign qBit    = ~diff[WIDTH];
  assign nextRem = qBit ? diff[WIDTH-1:0] : partRem[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative MIPS DIV/DIVU: one quotient bit per cycle, result {HI=rem, LO=quo}.
// Optional DIV_EARLY_ZERO_EN: a zero divisor skips the iterations and finishes in one cycle.
module div_unit import div_unit_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave divBus
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  divStateT state, nextState;

  logic [CNT_W-1:0]   iterCnt;
  logic [WIDTH-1:0]   remReg, quoReg, divisorReg;
  logic               quoNeg, remNeg;
  logic               readyReg;
  logic [2*WIDTH-1:0] resultReg;

  logic [WIDTH-1:0] absA, absB, nextRem, finalQuo, finalRem, stepQuo;
  logic             qBit, accept, lastIter, earlyZero;

`ifdef DIV_EARLY_ZERO_EN
  assign earlyZero = (divBus.b == '0);
`else
  assign earlyZero = 1'b0;
`endif

  // A new operation is taken from IDLE or from DONE; BUSY ignores start.
  assign accept   = divBus.start & ~divBus.annul & (state != BUSY);
  assign lastIter = (state == BUSY) && (iterCnt == LAST_ITER);

  assign absA = (divBus.signed_div && divBus.a[WIDTH-1]) ? -divBus.a : divBus.a;
  assign absB = (divBus.signed_div && divBus.b[WIDTH-1]) ? -divBus.b : divBus.b;

  div_step #(.WIDTH(WIDTH)) uStep (
    .partRem ({remReg, quoReg[WIDTH-1]}),
    .divisor (divisorReg),
    .nextRem (nextRem),
    .qBit    (qBit)
  );

  assign stepQuo  = {quoReg[WIDTH-2:0], qBit};
  assign finalQuo = quoNeg ? -stepQuo : stepQuo;
  assign finalRem = remNeg ? -nextRem : nextRem;

  assign divBus.stall  = (divBus.start & ~divBus.annul & (state != BUSY) & (state != DONE))
                       | (state == BUSY);
  assign divBus.ready  = readyReg;
  assign divBus.result = resultReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (divBus.annul) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) nextState = earlyZero ? DONE : BUSY;
        BUSY:    if (lastIter) nextState = DONE;
        DONE:    nextState = accept ? (earlyZero ? DONE : BUSY) : IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iterCnt    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      readyReg   <= 1'b0;
      resultReg  <= '0;
    end else begin
      readyReg <= (nextState == DONE);
      if (accept) begin
        iterCnt    <= '0;
        remReg     <= '0;
        quoReg     <= absA;
        divisorReg <= absB;
        quoNeg     <= divBus.signed_div & (divBus.a[WIDTH-1] ^ divBus.b[WIDTH-1]);
        remNeg     <= divBus.signed_div & divBus.a[WIDTH-1];
        if (earlyZero) begin
          resultReg[DIV_REM_FIELD*WIDTH +: WIDTH] <= divBus.a;
          resultReg[DIV_QUO_FIELD*WIDTH +: WIDTH] <= '1;
        end
      end else if ((state == BUSY) && !divBus.annul) begin
        // quoReg shifts dividend bits out the top and quotient bits in the bottom
        iterCnt <= iterCnt + 1'b1;
        remReg  <= nextRem;
        quoReg  <= stepQuo;
        if (lastIter) begin
          resultReg[DIV_REM_FIELD*WIDTH +: WIDTH] <= finalRem;
          resultReg[DIV_QUO_FIELD*WIDTH +: WIDTH] <= finalQuo;
        end
      end
    end
  end

endmodule
